// File: rtl/serial_mag_compare_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the one-hot {lt,gt,eq} result words.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

  function automatic logic [2:0] res_from_bits(input logic lt_bit, input logic gt_bit);
    if (lt_bit) begin
      return RES_LT;
    end else if (gt_bit) begin
      return RES_GT;
    end
    return RES_EQ;
  endfunction

endpackage

// File: rtl/serial_mag_compare_bit_cmp_cell.sv
// Single-bit combinational magnitude cell: exactly one of lt/gt/eq is high.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt,
  output logic eq
);

  assign lt = ~a &  b;
  assign gt =  a & ~b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_compare.sv
// MSB-first serial magnitude comparator with valid/ready in and out.
// Define SIGNED_CMP_EN to treat operands as two's complement.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter  int unsigned W     = 8,
  localparam int unsigned IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [IDX_W-1:0] pos
);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic [2:0]       res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic cell_lt, cell_gt, cell_eq;
  logic lt_bit, gt_bit;

  bit_cmp_cell u_cell (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .lt (cell_lt),
    .gt (cell_gt),
    .eq (cell_eq)
  );

`ifdef SIGNED_CMP_EN
  // A set sign bit marks the negative operand, so the cell's sense flips there only.
  logic sign_step;
  assign sign_step = (idx_q == IDX_W'(W - 1));
  assign lt_bit    = sign_step ? cell_gt : cell_lt;
  assign gt_bit    = sign_step ? cell_lt : cell_gt;
`else
  assign lt_bit = cell_lt;
  assign gt_bit = cell_gt;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(W - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!cell_eq) begin
          res_d       = res_from_bits(lt_bit, gt_bit);
          pos_d       = idx_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          res_d       = RES_EQ;
          pos_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d       = RES_NONE;
          pos_d       = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      pos_q       <= '0;
      res_q       <= RES_NONE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign {lt, gt, eq} = res_q;
  assign pos          = pos_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare (W=8); honours SIGNED_CMP_EN.
module tb_serial_mag_compare;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         lt, gt, eq;
  logic [2:0]   pos;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_mag_compare #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .gt        (gt),
    .eq        (eq),
    .pos       (pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference: ordering from plain (signed) arithmetic, pos from the top set bit of a^b.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [2:0] res, output int p, output int k);
    logic [W-1:0] d;
    bit is_lt;
    d = av ^ bv;
    p = 0;
    for (int i = 0; i < W; i++) if (d[i]) p = i;
`ifdef SIGNED_CMP_EN
    is_lt = $signed(av) < $signed(bv);
`else
    is_lt = av < bv;
`endif
    if (d == '0) begin
      res = 3'b001;
      k   = W;
    end else begin
      res = is_lt ? 3'b100 : 3'b010;
      k   = W - p;
    end
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
  } txn_t;
  txn_t exp_q[$];
  bit   prev_ov = 1'b0;

  always @(negedge clk) begin
    logic [2:0] r;
    int p, k;
    txn_t t;
    if (rst) begin
      exp_q.delete();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out", {out_valid, lt, gt, eq, pos}, 0);
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          t = exp_q[0];
          model(t.a, t.b, r, p, k);
          chk("mon_res", {lt, gt, eq}, 32'(r));
          chk("mon_pos", 32'(pos), 32'(p));
          if (!prev_ov) chk("mon_latency", cyc - t.acc, k);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("mon_idle_zero", {lt, gt, eq, pos}, 0);
      end
      if (in_valid && in_ready) begin
        t.a = a; t.b = b; t.acc = cyc + 1;
        exp_q.push_back(t);
      end
      prev_ov = out_valid;
    end
  end

  // Presents a pair (caller sits #1 after an edge) until accepted; then scrambles a/b.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, output int acc);
    int n = 0;
    in_valid = 1'b1; a = av; b = bv;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_result(output int lat, input int acc);
    int n = 0;
    while (!out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        chk("result_timeout", 1, 0);
        break;
      end
    end
    lat = cyc - acc;
  endtask

  initial begin
    int acc, lat, prev_acc, prev_k, p, k;
    logic [2:0] r, hold;
    logic [2:0] hold_pos;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_outputs", {out_valid, lt, gt, eq, pos}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: equal operands
    send(8'hA5, 8'hA5, acc);
    wait_result(lat, acc);
    chk("t1_res", {lt, gt, eq}, 3'b001);
    chk("t1_pos", 32'(pos), 0);
    chk("t1_lat", lat, 8);
    @(posedge clk); #1;

    // 2: decided on the MSB
    send(8'h80, 8'h7F, acc);
    wait_result(lat, acc);
`ifdef SIGNED_CMP_EN
    chk("t2_res", {lt, gt, eq}, 3'b100);
`else
    chk("t2_res", {lt, gt, eq}, 3'b010);
`endif
    chk("t2_pos", 32'(pos), 7);
    chk("t2_lat", lat, 1);
    @(posedge clk); #1;

    // 3: decided on LSB, then on bit 3
    send(8'h12, 8'h13, acc);
    wait_result(lat, acc);
    chk("t3a_res", {lt, gt, eq}, 3'b100);
    chk("t3a_pos", 32'(pos), 0);
    chk("t3a_lat", lat, 8);
    @(posedge clk); #1;
    send(8'h3C, 8'h34, acc);
    wait_result(lat, acc);
    chk("t3b_res", {lt, gt, eq}, 3'b010);
    chk("t3b_pos", 32'(pos), 3);
    chk("t3b_lat", lat, 5);
    @(posedge clk); #1;

    // 4: back-pressure with in_valid held high
    out_ready = 1'b0;
    send(8'h3C, 8'h34, acc);
    in_valid = 1'b1; a = 8'h55; b = 8'h50;
    wait_result(lat, acc);
    hold = {lt, gt, eq};
    hold_pos = pos;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_res", {lt, gt, eq}, 32'(hold));
      chk("t4_hold_pos", 32'(pos), 32'(hold_pos));
      chk("t4_in_ready", 32'(in_ready), 0);
      chk("t4_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_after_hs_valid", 32'(out_valid), 0);
    chk("t4_after_hs_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("t4_accepted", 32'(in_ready), 0);
    acc = cyc;
    in_valid = 1'b0;
    wait_result(lat, acc);
    chk("t4b_res", {lt, gt, eq}, 3'b010);
    chk("t4b_pos", 32'(pos), 2);
    chk("t4b_lat", lat, 6);
    @(posedge clk); #1;

    // 5: reset in the middle of a scan
    send(8'h01, 8'h00, acc);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {out_valid, in_ready, lt, gt, eq, pos}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_result", 32'(out_valid), 0);
    end
    send(8'h01, 8'h00, acc);
    wait_result(lat, acc);
    chk("t5_res", {lt, gt, eq}, 3'b010);
    chk("t5_pos", 32'(pos), 0);
    chk("t5_lat", lat, 8);
    @(posedge clk); #1;

    // 6: back-to-back pairs, out_ready held high
    prev_acc = -1;
    prev_k = 0;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      send(ra, rb, acc);
      if (prev_acc >= 0) chk("t6_gap", acc - prev_acc, prev_k + 2);
      model(ra, rb, r, p, k);
      prev_acc = acc;
      prev_k = k;
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t6_drain", exp_q.size(), 0);
    end
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
